rat_recovery_ctrl: RTL and testbench

//  Write-port controller for the speculative RAT. In normal operation it forwards rename-stage writes to the RAT;
//  on a pipeline flush it takes the RAT write port and walks all arch entries, copying each mapping from the

---
 rtl/rat_recovery_ctrl_if.sv | 31 +++
 rtl/rat_recovery_ctrl.sv | 119 +++++++++++
 tb/tb_rat_recovery_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/rat_recovery_ctrl_if.sv
// Signal bundle between the RAT recovery controller and the rename stage, ROB flush, RRAT read and RAT write ports.
// master = controller side, slave = surrounding pipeline.
interface rat_recovery_ctrl_if #(
  parameter int ARCH_WIDTH = 5,
  parameter int PRF_WIDTH  = 7
);
  logic                  flush;
  logic                  rename_req;
  logic [ARCH_WIDTH-1:0] rename_arch;
  logic [PRF_WIDTH-1:0]  rename_phy;
  logic                  rename_stall;
  logic                  rat_rename_en;
  logic [ARCH_WIDTH-1:0] rat_arch_reg;
  logic [PRF_WIDTH-1:0]  rat_new_phy_reg;
  logic [ARCH_WIDTH-1:0] rrat_idx;
  logic [PRF_WIDTH-1:0]  rrat_phy;
  logic                  recov_busy;
  logic                  recov_done;

  modport master (
    input  flush, rename_req, rename_arch, rename_phy, rrat_phy,
    output rename_stall, rat_rename_en, rat_arch_reg, rat_new_phy_reg,
           rrat_idx, recov_busy, recov_done
  );

  modport slave (
    output flush, rename_req, rename_arch, rename_phy, rrat_phy,
    input  rename_stall, rat_rename_en, rat_arch_reg, rat_new_phy_reg,
           rrat_idx, recov_busy, recov_done
  );
endinterface

// File: rtl/rat_recovery_ctrl.sv
// Speculative-RAT write-port controller: forwards rename writes, and on flush copies every RRAT entry back into the RAT.
// Optional RAT_RECOV_PERF_EN adds saturating flush/stall performance counters.
module rat_recovery_ctrl #(
  parameter int ARCH_ENTRY = 32,
  parameter int ARCH_WIDTH = $clog2(ARCH_ENTRY),
  parameter int PRF_ENTRY  = 128,
  parameter int PRF_WIDTH  = $clog2(PRF_ENTRY)
) (
  input  logic                   clk,
  input  logic                   rst,
  rat_recovery_ctrl_if.master    bus
`ifdef RAT_RECOV_PERF_EN
  ,
  output logic [31:0]            perf_flush_cnt,
  output logic [31:0]            perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_e;

  state_e                state_q, state_d;
  logic [ARCH_WIDTH-1:0] idx_q, idx_d;

  logic                  wr_en;
  logic [ARCH_WIDTH-1:0] wr_arch;
  logic [PRF_WIDTH-1:0]  wr_phy;
  logic [ARCH_WIDTH-1:0] rd_idx;
  logic                  stall, busy, done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_en   = 1'b0;
    wr_arch = bus.rename_arch;
    wr_phy  = bus.rename_phy;
    rd_idx  = '0;
    stall   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A same-cycle flush wins over the rename write.
        wr_en = bus.rename_req & ~bus.flush;
        if (bus.flush) begin
          state_d = WALK;
          idx_d   = '0;
        end
      end
      WALK: begin
        wr_en   = 1'b1;
        rd_idx  = idx_q;
        wr_arch = idx_q;
        wr_phy  = bus.rrat_phy;
        stall   = 1'b1;
        busy    = 1'b1;
        if (bus.flush) begin
          idx_d = '0;
        end else if (idx_q == ARCH_WIDTH'(ARCH_ENTRY - 1)) begin
          state_d = DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        stall = 1'b1;
        busy  = 1'b1;
        done  = 1'b1;
        if (bus.flush) begin
          state_d = WALK;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign bus.rat_rename_en   = wr_en;
  assign bus.rat_arch_reg    = wr_arch;
  assign bus.rat_new_phy_reg = wr_phy;
  assign bus.rrat_idx        = rd_idx;
  assign bus.rename_stall    = stall;
  assign bus.recov_busy      = busy;
  assign bus.recov_done      = done;

`ifdef RAT_RECOV_PERF_EN
  logic [31:0] flush_cnt_q, stall_cnt_q;

  // Every flush is accepted in every state, so restarts count too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (bus.flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
      if (stall && (stall_cnt_q != '1))     stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_flush_cnt = flush_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rat_recovery_ctrl.sv
// Scoreboard bench for rat_recovery_ctrl: expected RAT writes are queued as stimulus is driven and popped on each write.
module tb_rat_recovery_ctrl;

  localparam int AW = 5;
  localparam int PW = 7;

  logic clk;
  logic rst;

  rat_recovery_ctrl_if #(.ARCH_WIDTH(AW), .PRF_WIDTH(PW)) bus ();

`ifdef RAT_RECOV_PERF_EN
  logic [31:0] perf_flush_cnt, perf_stall_cnt;
`endif

  rat_recovery_ctrl #(.ARCH_ENTRY(32), .PRF_ENTRY(128)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef RAT_RECOV_PERF_EN
    ,
    .perf_flush_cnt (perf_flush_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  logic [PW-1:0] rrat_mem [32];
  assign bus.rrat_phy = rrat_mem[bus.rrat_idx];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  logic [AW+PW-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_walk(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      logic [AW-1:0] a;
      a = AW'(i);
      exp_q.push_back({a, rrat_mem[i]});
    end
  endtask

  // Write monitor: every RAT write must match the next queued expectation.
  always @(negedge clk) begin
    if (bus.recov_done === 1'b1) done_cnt++;
    if (bus.rat_rename_en === 1'b1) begin
      chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [AW+PW-1:0] e;
        e = exp_q.pop_front();
        chk("wr_arch", 32'(bus.rat_arch_reg), 32'(e[AW+PW-1:PW]));
        chk("wr_phy", 32'(bus.rat_new_phy_reg), 32'(e[PW-1:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    for (int i = 0; i < 32; i++) rrat_mem[i] = PW'(i + 32);
    rst             = 1'b1;
    bus.flush       = 1'b0;
    bus.rename_req  = 1'b0;
    bus.rename_arch = '0;
    bus.rename_phy  = '0;
    repeat (2) step();

    chk("rst_stall", 32'(bus.rename_stall), 32'd0);
    chk("rst_busy", 32'(bus.recov_busy), 32'd0);
    chk("rst_done", 32'(bus.recov_done), 32'd0);
    chk("rst_rrat_idx", 32'(bus.rrat_idx), 32'd0);
    chk("rst_wr_en", 32'(bus.rat_rename_en), 32'd0);
    rst = 1'b0;
    step();

    // 1: plain rename forwarding
    bus.rename_req = 1'b1; bus.rename_arch = 5'd5; bus.rename_phy = 7'h40;
    exp_q.push_back({5'd5, 7'h40});
    @(negedge clk);
    chk("t1_stall", 32'(bus.rename_stall), 32'd0);
    chk("t1_wr_en", 32'(bus.rat_rename_en), 32'd1);
    step();
    bus.rename_req = 1'b0;

    // 2: full walk timing
    d0 = done_cnt;
    bus.flush = 1'b1;
    push_walk(0, 31);
    @(negedge clk);
    chk("t2_stall_t0", 32'(bus.rename_stall), 32'd0);
    step();
    bus.flush = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("t2_walk_stall", 32'(bus.rename_stall), 32'd1);
      chk("t2_walk_done", 32'(bus.recov_done), 32'd0);
      step();
    end
    @(negedge clk);
    chk("t2_done", 32'(bus.recov_done), 32'd1);
    chk("t2_done_stall", 32'(bus.rename_stall), 32'd1);
    chk("t2_done_wr_en", 32'(bus.rat_rename_en), 32'd0);
    step();
    bus.rename_req = 1'b1; bus.rename_arch = 5'd3; bus.rename_phy = 7'h11;
    exp_q.push_back({5'd3, 7'h11});
    @(negedge clk);
    chk("t2_accept_stall", 32'(bus.rename_stall), 32'd0);
    chk("t2_accept_busy", 32'(bus.recov_busy), 32'd0);
    step();
    bus.rename_req = 1'b0;
    chk("t2_done_pulses", 32'(done_cnt - d0), 32'd1);

    // 3: flush beats same-cycle rename
    bus.flush = 1'b1; bus.rename_req = 1'b1; bus.rename_arch = 5'd9; bus.rename_phy = 7'h22;
    push_walk(0, 31);
    @(negedge clk);
    chk("t3_wr_en", 32'(bus.rat_rename_en), 32'd0);
    step();
    bus.flush = 1'b0; bus.rename_req = 1'b0;
    @(negedge clk);
    chk("t3_first_idx", 32'(bus.rrat_idx), 32'd0);
    repeat (32) step();
    @(negedge clk);
    chk("t3_done", 32'(bus.recov_done), 32'd1);
    step();

    // 4: restart at idx 10
    d0 = done_cnt;
    bus.flush = 1'b1;
    push_walk(0, 10);
    step();
    bus.flush = 1'b0;
    repeat (10) step();
    bus.flush = 1'b1;
    push_walk(0, 31);
    @(negedge clk);
    chk("t4_restart_idx", 32'(bus.rrat_idx), 32'd10);
    chk("t4_restart_wr", 32'(bus.rat_rename_en), 32'd1);
    step();
    bus.flush = 1'b0;
    @(negedge clk);
    chk("t4_after_idx", 32'(bus.rrat_idx), 32'd0);
    repeat (32) step();
    @(negedge clk);
    chk("t4_done", 32'(bus.recov_done), 32'd1);
    step();
    chk("t4_done_pulses", 32'(done_cnt - d0), 32'd1);

    // 5: async reset mid-walk at idx 20
    bus.flush = 1'b1;
    push_walk(0, 19);
    step();
    bus.flush = 1'b0;
    repeat (20) step();
    rst = 1'b1;
    #1;
    chk("t5_stall", 32'(bus.rename_stall), 32'd0);
    chk("t5_busy", 32'(bus.recov_busy), 32'd0);
    chk("t5_rrat_idx", 32'(bus.rrat_idx), 32'd0);
    chk("t5_wr_en", 32'(bus.rat_rename_en), 32'd0);
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    // 6: two back-to-back recoveries
    d0 = done_cnt;
    bus.flush = 1'b1;
    push_walk(0, 31);
    step();
    bus.flush = 1'b0;
    repeat (33) step();
    bus.flush = 1'b1;
    push_walk(0, 31);
    step();
    bus.flush = 1'b0;
    repeat (33) step();
    @(negedge clk);
    chk("t6_done_pulses", 32'(done_cnt - d0), 32'd2);
`ifdef RAT_RECOV_PERF_EN
    chk("t6_perf_flush", perf_flush_cnt, 32'd2);
    chk("t6_perf_stall", perf_stall_cnt, 32'd66);
`endif
    step();

    chk("wr_left", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
